// File: rtl/uart_frame_sender.sv
// Frame sequencer for uart_tx: sends two header bytes, every pixel byte read from
// the synchronous image RAM, then a modulo-256 checksum of the pixel bytes.
//
// state   | meaning
// IDLE    | waiting for i_Start
// HDR_A   | DV for first header byte
// HDR_B   | DV for second header byte
// FETCH   | read strobe for current pixel
// MEM     | RAM data valid, captured into the tx byte
// SEND    | DV for pixel byte
// CKSUM   | DV for checksum byte
// WAIT_TX | waiting for i_Tx_Done rising edge
// GAP     | waiting for uart_tx to be fully idle
// FINISH  | o_Done pulse
module uart_frame_sender #(
    parameter int          IMG_WIDTH  = 64,
    parameter int          IMG_HEIGHT = 64,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  HDR0       = 8'hAA,
    parameter logic [7:0]  HDR1       = 8'h55
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_Rd,
    input  logic [7:0]        i_Mem_Data,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam int                NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_A, S_HDR_B, S_FETCH, S_MEM,
        S_SEND, S_CKSUM, S_WAIT_TX, S_GAP, S_FINISH
    } state_t;

    state_t            r_state;
    state_t            r_next;
    logic [ADDR_W-1:0] r_pix;
    logic [7:0]        r_cksum;
    logic              r_tx_done_q;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd;
    logic              r_dv;
    logic [7:0]        r_byte;

    // Outputs are registered: each strobe is raised on the edge that enters
    // the state in which it is visible.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_next      <= S_IDLE;
            r_pix       <= '0;
            r_cksum     <= '0;
            r_tx_done_q <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_dv        <= 1'b0;
            r_byte      <= '0;
        end else begin
            r_tx_done_q <= i_Tx_Done;
            r_dv        <= 1'b0;
            r_rd        <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_state <= S_HDR_A;
                        r_busy  <= 1'b1;
                        r_pix   <= '0;
                        r_cksum <= '0;
                        r_dv    <= 1'b1;
                        r_byte  <= HDR0;
                    end
                end
                S_HDR_A: begin
                    r_next  <= S_HDR_B;
                    r_state <= S_WAIT_TX;
                end
                S_HDR_B: begin
                    r_next  <= S_FETCH;
                    r_state <= S_WAIT_TX;
                end
                S_FETCH: r_state <= S_MEM;
                S_MEM: begin
                    r_byte  <= i_Mem_Data;
                    r_cksum <= r_cksum + i_Mem_Data;
                    r_dv    <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_next  <= (r_pix == LAST_PIX) ? S_CKSUM : S_FETCH;
                    r_pix   <= r_pix + ADDR_W'(1);
                    r_state <= S_WAIT_TX;
                end
                S_CKSUM: begin
                    r_next  <= S_FINISH;
                    r_state <= S_WAIT_TX;
                end
                // A held i_Tx_Done only produces one edge, so one advance per byte.
                S_WAIT_TX: begin
                    if (i_Tx_Done && !r_tx_done_q)
                        r_state <= S_GAP;
                end
                S_GAP: begin
                    if (!i_Tx_Done && !i_Tx_Active) begin
                        r_state <= r_next;
                        case (r_next)
                            S_HDR_B: begin
                                r_dv   <= 1'b1;
                                r_byte <= HDR1;
                            end
                            S_FETCH: begin
                                r_rd   <= 1'b1;
                                r_addr <= r_pix;
                            end
                            S_CKSUM: begin
                                r_dv   <= 1'b1;
                                r_byte <= r_cksum;
                            end
                            S_FINISH: r_done <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Busy     = r_busy;
    assign o_Done     = r_done;
    assign o_Mem_Addr = r_addr;
    assign o_Mem_Rd   = r_rd;
    assign o_Tx_DV    = r_dv;
    assign o_Tx_Byte  = r_byte;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Randomized bench for uart_frame_sender: a queue-based frame model and a uart_tx
// model with random busy/done lengths, checked every cycle on the falling edge.
module tb_uart_frame_sender;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          o_Busy, o_Done, o_Mem_Rd, o_Tx_DV;
    logic [AW-1:0] o_Mem_Addr;
    logic [7:0]    o_Tx_Byte;
    logic [7:0]    mem_data = 8'h00;
    logic          tx_act = 1'b0;
    logic          tx_done = 1'b0;

    logic [7:0] ram [NPIX];

    int total = 0;
    int bad   = 0;

    // frame model
    bit         m_busy = 1'b0;
    logic [7:0] q [$];
    int         exp_addr = 0;
    int         frame_dv = 0;
    int         last_frame_dv = 0;
    int         done_cnt = 0;
    bit         exp_dv_next = 1'b0;
    logic [7:0] last_sent = 8'h00;
    int         done_hold = 0;

    always #5 clk = ~clk;

    uart_frame_sender #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .HDR0(8'hAA), .HDR1(8'h55)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start),
        .o_Busy(o_Busy), .o_Done(o_Done),
        .o_Mem_Addr(o_Mem_Addr), .o_Mem_Rd(o_Mem_Rd), .i_Mem_Data(mem_data),
        .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
        .i_Tx_Active(tx_act), .i_Tx_Done(tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // synchronous-read image RAM
    always @(posedge clk) if (o_Mem_Rd) mem_data <= ram[o_Mem_Addr[2:0]];

    // uart_tx model: Active for 2..5 cycles after a DV, then Done for 1..3 cycles
    initial begin
        int  phase = 0;
        int  cnt = 0;
        bit  dvs;
        forever begin
            @(negedge clk);
            dvs = o_Tx_DV;
            @(posedge clk);
            #1;
            if (rst) begin
                tx_act = 1'b0; tx_done = 1'b0; phase = 0;
            end else begin
                case (phase)
                    0: if (dvs) begin
                        tx_act = 1'b1; cnt = $urandom_range(2, 5); phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            tx_act = 1'b0; tx_done = 1'b1;
                            cnt = (done_hold > 0) ? done_hold : $urandom_range(1, 3);
                            phase = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin tx_done = 1'b0; phase = 0; end
                    end
                endcase
            end
        end
    end

    // per-cycle compare against the frame model
    initial begin
        logic [7:0] e;
        int         sum;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", o_Busy, 0);
                chk("rst_dv", o_Tx_DV, 0);
                chk("rst_rd", o_Mem_Rd, 0);
                chk("rst_done", o_Done, 0);
                m_busy = 1'b0; q.delete(); exp_dv_next = 1'b0;
            end else begin
                chk("busy", o_Busy, m_busy);
                if (exp_dv_next) chk("start_latency_dv", o_Tx_DV, 1);
                exp_dv_next = 1'b0;
                if (o_Tx_DV) begin
                    chk("dv_while_tx", tx_act | tx_done, 0);
                    frame_dv++;
                    if (q.size() == 0) fail_now("extra_dv");
                    else begin
                        e = q.pop_front();
                        chk("tx_byte", o_Tx_Byte, e);
                        last_sent = o_Tx_Byte;
                    end
                end
                if (o_Mem_Rd) begin
                    chk("mem_addr", o_Mem_Addr, exp_addr);
                    exp_addr++;
                end
                if (o_Done) begin
                    chk("done_bytes_left", q.size(), 0);
                    done_cnt++;
                    last_frame_dv = frame_dv;
                    m_busy = 1'b0;
                end else if (start && !m_busy) begin
                    m_busy = 1'b1;
                    q.delete();
                    q.push_back(8'hAA);
                    q.push_back(8'h55);
                    sum = 0;
                    for (int i = 0; i < NPIX; i++) begin
                        q.push_back(ram[i]);
                        sum += int'(ram[i]);
                    end
                    q.push_back(8'(sum % 256));
                    exp_addr = 0; frame_dv = 0; exp_dv_next = 1'b1;
                end
            end
        end
    end

    // mode 0: normal, 3: re-pulse start after 3rd DV, 5: reset after 5th DV
    task automatic run_frame(input int mode);
        int n;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        if (mode != 0) begin
            n = 0;
            while (frame_dv < mode && n < 2000) begin @(posedge clk); #1; n++; end
            if (n >= 2000) fail_now("timeout_dv_wait");
            if (mode == 3) begin
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end else begin
                rst = 1'b1; #1;
                chk("async_rst_busy", o_Busy, 0);
                chk("async_rst_byte", o_Tx_Byte, 0);
                chk("async_rst_addr", o_Mem_Addr, 0);
                chk("async_rst_dv", o_Tx_DV, 0);
                repeat (3) @(posedge clk);
                #1; rst = 1'b0;
                return;
            end
        end
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            if (o_Done) break;
            n++;
        end
        if (n >= 3000) fail_now("timeout_done");
    endtask

    initial begin
        int d0;
        for (int i = 0; i < NPIX; i++) ram[i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", o_Busy, 0);
        chk("reset_byte", o_Tx_Byte, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // T1
        d0 = done_cnt;
        run_frame(0);
        @(negedge clk); #1;
        chk("t1_dvs", last_frame_dv, 11);
        chk("t1_cksum", last_sent, 8'h24);
        chk("t1_done", done_cnt - d0, 1);

        // T2
        for (int i = 0; i < NPIX; i++) ram[i] = 8'hFF;
        run_frame(0);
        @(negedge clk); #1;
        chk("t2_cksum", last_sent, 8'hF8);
        @(negedge clk);
        chk("t2_busy_low", o_Busy, 0);

        // T3
        for (int i = 0; i < NPIX; i++) ram[i] = 8'(i + 1);
        d0 = done_cnt;
        run_frame(3);
        repeat (80) @(posedge clk);
        #1;
        chk("t3_dvs", last_frame_dv, 11);
        chk("t3_single_done", done_cnt - d0, 1);
        chk("t3_idle", o_Busy, 0);

        // T4
        done_hold = 2;
        d0 = done_cnt;
        run_frame(0);
        @(negedge clk); #1;
        chk("t4_dvs", last_frame_dv, 11);
        chk("t4_done", done_cnt - d0, 1);
        done_hold = 0;
        repeat (3) @(posedge clk);

        // T5
        d0 = done_cnt;
        run_frame(5);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - d0, 0);
        run_frame(0);
        @(negedge clk); #1;
        chk("t5_dvs", last_frame_dv, 11);
        chk("t5_cksum", last_sent, 8'h24);

        // T6: start on the cycle after o_Done
        d0 = done_cnt;
        run_frame(0);
        @(negedge clk); #1;
        run_frame(0);
        @(negedge clk); #1;
        chk("t6_dvs", last_frame_dv, 11);
        chk("t6_cksum", last_sent, 8'h24);
        chk("t6_done", done_cnt - d0, 2);

        // random frames
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom_range(0, 255));
            done_hold = $urandom_range(0, 3);
            d0 = done_cnt;
            run_frame(0);
            @(negedge clk); #1;
            chk("rand_dvs", last_frame_dv, NPIX + 3);
            chk("rand_done", done_cnt - d0, 1);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
